// File: rtl/seg_display_writer.sv
// Bus-write scheduler for the ten-digit 7-segment display: mirrors the last
// written words and rewrites changed words round-robin, plus full refreshes.
module seg_display_writer #(
    parameter logic [31:0] BASEADDR       = 32'hF000_0010,
    parameter int unsigned REFRESH_PERIOD = 1000,
    parameter int unsigned CNTWIDTH       = 20
) (
    input  logic        wClk,
    input  logic        nwReset,
    input  logic [79:0] bCode,
    input  logic        wEnable,
    input  logic        wForceRefresh,
    output logic        wWrite,
    output logic [31:0] bWriteAddr,
    output logic [31:0] bWriteData,
    output logic [3:0]  bWriteMask,
    output logic        wBusy
);
    localparam int unsigned NWORDS  = 3;
    localparam int unsigned WORDW   = 32;
    localparam int unsigned HALFW   = 16;
    localparam logic [3:0] MASK_ALL = 4'b0000;
    localparam logic [3:0] MASK_LOW = 4'b1100;

    logic [WORDW-1:0]  word0;
    logic [WORDW-1:0]  word1;
    logic [HALFW-1:0]  word2;
    logic [WORDW-1:0]  shadow0;
    logic [WORDW-1:0]  shadow1;
    logic [HALFW-1:0]  shadow2;
    logic [NWORDS-1:0] pend;
    logic [NWORDS-1:0] pendNext;
    logic [NWORDS-1:0] dirty;
    logic [1:0]        ptr;
    logic [1:0]        cand0;
    logic [1:0]        cand1;
    logic [1:0]        cand2;
    logic              grantValid;
    logic [1:0]        grantIdx;
    logic [WORDW-1:0]  grantData;
    logic [3:0]        grantMask;
    logic              refreshTick;

    assign word0 = bCode[31:0];
    assign word1 = bCode[63:32];
    assign word2 = bCode[79:64];

    assign dirty[0] = (word0 != shadow0) | pend[0];
    assign dirty[1] = (word1 != shadow1) | pend[1];
    assign dirty[2] = (word2 != shadow2) | pend[2];
    assign wBusy    = |dirty;

    function automatic logic [1:0] nextIdx(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Round-robin search starting after the last granted word
    always_comb begin
        cand0      = nextIdx(ptr);
        cand1      = nextIdx(cand0);
        cand2      = nextIdx(cand1);
        grantValid = 1'b0;
        grantIdx   = 2'd0;
        if (wEnable) begin
            if (dirty[cand0]) begin
                grantValid = 1'b1;
                grantIdx   = cand0;
            end else if (dirty[cand1]) begin
                grantValid = 1'b1;
                grantIdx   = cand1;
            end else if (dirty[cand2]) begin
                grantValid = 1'b1;
                grantIdx   = cand2;
            end
        end
    end

    always_comb begin
        grantData = word0;
        grantMask = MASK_ALL;
        case (grantIdx)
            2'd0:    grantData = word0;
            2'd1:    grantData = word1;
            default: begin
                grantData = {HALFW'(0), word2};
                grantMask = MASK_LOW;
            end
        endcase
    end

    // Refresh/force sets win over the grant clear so no request is dropped
    always_comb begin
        pendNext = pend;
        if (grantValid) begin
            pendNext[grantIdx] = 1'b0;
        end
        if (refreshTick || wForceRefresh) begin
            pendNext = '1;
        end
    end

    if (REFRESH_PERIOD == 0) begin : gNoRefresh
        assign refreshTick = 1'b0;
    end else begin : gRefresh
        localparam logic [CNTWIDTH-1:0] CNT_LAST = CNTWIDTH'(REFRESH_PERIOD - 1);
        logic [CNTWIDTH-1:0] refreshCnt;

        always_ff @(posedge wClk) begin
            if (!nwReset) begin
                refreshCnt <= '0;
            end else if (refreshCnt == CNT_LAST) begin
                refreshCnt <= '0;
            end else begin
                refreshCnt <= refreshCnt + CNTWIDTH'(1);
            end
        end

        assign refreshTick = (refreshCnt == CNT_LAST);
    end

    always_ff @(posedge wClk) begin
        if (!nwReset) begin
            wWrite     <= 1'b0;
            bWriteAddr <= '0;
            bWriteData <= '0;
            bWriteMask <= '0;
            shadow0    <= '0;
            shadow1    <= '0;
            shadow2    <= '0;
            pend       <= '1;
            ptr        <= 2'd2;
        end else begin
            wWrite <= grantValid;
            pend   <= pendNext;
            if (grantValid) begin
                bWriteAddr <= BASEADDR + WORDW'({grantIdx, 2'b00});
                bWriteData <= grantData;
                bWriteMask <= grantMask;
                ptr        <= grantIdx;
                case (grantIdx)
                    2'd0:    shadow0 <= word0;
                    2'd1:    shadow1 <= word1;
                    default: shadow2 <= word2;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seg_display_writer.sv
// Bench for seg_display_writer: directed scenarios plus randomized traffic
// against a transaction-level model, for refresh-disabled and period-8 instances.
module tb_seg_display_writer;
    localparam logic [31:0] BASE = 32'hF000_0010;

    logic        wClk = 1'b0;
    logic        nwReset;
    logic        wEnable;
    logic        wForceRefresh;
    logic [79:0] bCode;

    logic        wWriteA, wBusyA, wWriteB, wBusyB;
    logic [31:0] bWriteAddrA, bWriteDataA, bWriteAddrB, bWriteDataB;
    logic [3:0]  bWriteMaskA, bWriteMaskB;
    logic [69:0] obsA, obsB;

    assign obsA = {wWriteA, bWriteAddrA, bWriteDataA, bWriteMaskA, wBusyA};
    assign obsB = {wWriteB, bWriteAddrB, bWriteDataB, bWriteMaskB, wBusyB};

    seg_display_writer #(.BASEADDR(BASE), .REFRESH_PERIOD(0), .CNTWIDTH(20)) dutA (
        .wClk(wClk), .nwReset(nwReset), .bCode(bCode), .wEnable(wEnable),
        .wForceRefresh(wForceRefresh), .wWrite(wWriteA), .bWriteAddr(bWriteAddrA),
        .bWriteData(bWriteDataA), .bWriteMask(bWriteMaskA), .wBusy(wBusyA));

    seg_display_writer #(.BASEADDR(BASE), .REFRESH_PERIOD(8), .CNTWIDTH(4)) dutB (
        .wClk(wClk), .nwReset(nwReset), .bCode(bCode), .wEnable(wEnable),
        .wForceRefresh(wForceRefresh), .wWrite(wWriteB), .bWriteAddr(bWriteAddrB),
        .bWriteData(bWriteDataB), .bWriteMask(bWriteMaskB), .wBusy(wBusyB));

    always #5 wClk = ~wClk;

    int tests = 0;
    int fails = 0;

    // Reference model state, index 0 = no refresh, 1 = period 8
    int          period [2] = '{0, 8};
    logic [31:0] mShadow [2][3];
    bit          mPend [2][3];
    int          mLast [2];
    int          mK [2];
    logic        eWrite [2];
    logic [31:0] eAddr [2];
    logic [31:0] eData [2];
    logic [3:0]  eMask [2];
    logic        eBusy [2];

    function automatic logic [31:0] wordOf(input logic [79:0] code, input int i);
        if (i == 2) return {16'h0, code[79:64]};
        return code[32*i +: 32];
    endfunction

    function automatic logic [69:0] expVec(input int m);
        return {eWrite[m], eAddr[m], eData[m], eMask[m], eBusy[m]};
    endfunction

    function automatic void modelEdge();
        int g;
        int c;
        bit tick;
        bit b;
        for (int m = 0; m < 2; m++) begin
            if (!nwReset) begin
                for (int i = 0; i < 3; i++) begin
                    mShadow[m][i] = 32'h0;
                    mPend[m][i]   = 1'b1;
                end
                mLast[m] = 2; mK[m] = 0;
                eWrite[m] = 1'b0; eAddr[m] = 32'h0; eData[m] = 32'h0; eMask[m] = 4'h0;
            end else begin
                g = -1;
                mK[m]++;
                tick = (period[m] != 0) && (mK[m] % period[m] == 0);
                if (wEnable) begin
                    for (int j = 1; j <= 3; j++) begin
                        c = (mLast[m] + j) % 3;
                        if (g < 0 && (wordOf(bCode, c) !== mShadow[m][c] || mPend[m][c])) g = c;
                    end
                end
                eWrite[m] = (g >= 0);
                if (g >= 0) begin
                    eAddr[m] = BASE + 32'(4 * g);
                    eData[m] = wordOf(bCode, g);
                    eMask[m] = (g == 2) ? 4'b1100 : 4'b0000;
                    mShadow[m][g] = wordOf(bCode, g);
                    mPend[m][g] = 1'b0;
                    mLast[m] = g;
                end
                if (tick || wForceRefresh) begin
                    for (int i = 0; i < 3; i++) mPend[m][i] = 1'b1;
                end
            end
            b = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (wordOf(bCode, i) !== mShadow[m][i] || mPend[m][i]) b = 1'b1;
            end
            eBusy[m] = b;
        end
    endfunction

    task automatic step();
        @(posedge wClk);
        modelEdge();
        #1;
    endtask

    task automatic test_reset();
        nwReset = 1'b0; wEnable = 1'b1; wForceRefresh = 1'b0;
        bCode = {10{8'h3F}};
        step(); step();
        tests++;
        if (obsA !== {1'b0, 32'h0, 32'h0, 4'h0, 1'b1}) begin
            fails++; $display("FAIL reset_outputs_a obs=%h exp=%h", obsA, {1'b0, 32'h0, 32'h0, 4'h0, 1'b1});
        end
        tests++;
        if (obsB !== expVec(1)) begin
            fails++; $display("FAIL reset_outputs_b obs=%h exp=%h", obsB, expVec(1));
        end
    endtask

    task automatic test_power_on();
        logic [68:0] expW [3];
        expW[0] = {1'b1, 32'hF000_0010, 32'h3F3F3F3F, 4'b0000};
        expW[1] = {1'b1, 32'hF000_0014, 32'h3F3F3F3F, 4'b0000};
        expW[2] = {1'b1, 32'hF000_0018, 32'h00003F3F, 4'b1100};
        nwReset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (obsA[69:1] !== expW[i]) begin
                fails++; $display("FAIL power_on_write%0d obs=%h exp=%h", i, obsA[69:1], expW[i]);
            end
        end
        step();
        tests++;
        if (obsA !== {1'b0, 32'hF000_0018, 32'h00003F3F, 4'b1100, 1'b0}) begin
            fails++; $display("FAIL power_on_idle obs=%h exp=%h", obsA, {1'b0, 32'hF000_0018, 32'h00003F3F, 4'b1100, 1'b0});
        end
    endtask

    task automatic test_single_change();
        bCode[7:0] = 8'h06;
        step();
        tests++;
        if (obsA[69:5] !== {1'b1, 32'hF000_0010, 32'h3F3F3F06}) begin
            fails++; $display("FAIL single_change_write obs=%h exp=%h", obsA[69:5], {1'b1, 32'hF000_0010, 32'h3F3F3F06});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (wWriteA !== 1'b0) begin
                fails++; $display("FAIL single_change_quiet%0d obs=%b exp=0", i, wWriteA);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [68:0] expW [3];
        expW[0] = {1'b1, 32'hF000_0014, 32'h3F3F663F, 4'b0000};
        expW[1] = {1'b1, 32'hF000_0018, 32'h00007F3F, 4'b1100};
        expW[2] = {1'b1, 32'hF000_0010, 32'h3F3F5B06, 4'b0000};
        bCode[15:8] = 8'h5B; bCode[47:40] = 8'h66; bCode[79:72] = 8'h7F;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (obsA[69:1] !== expW[i]) begin
                fails++; $display("FAIL back_to_back_write%0d obs=%h exp=%h", i, obsA[69:1], expW[i]);
            end
        end
        step();
        tests++;
        if (obsA !== expVec(0) || wWriteA !== 1'b0) begin
            fails++; $display("FAIL back_to_back_idle obs=%h exp=%h", obsA, expVec(0));
        end
    endtask

    task automatic test_enable_hold();
        wEnable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bCode[39:32] = 8'h06;
            if (i == 3) bCode[39:32] = 8'h5B;
            if (i == 6) bCode[39:32] = 8'h06;
            if (i == 8) bCode[39:32] = 8'h4F;
            step();
            tests++;
            if (wWriteA !== 1'b0 || wBusyA !== 1'b1) begin
                fails++; $display("FAIL enable_hold_cycle%0d write=%b busy=%b exp write=0 busy=1", i, wWriteA, wBusyA);
            end
        end
        wEnable = 1'b1;
        step();
        tests++;
        if (obsA !== {1'b1, 32'hF000_0014, 32'h3F3F664F, 4'b0000, 1'b0}) begin
            fails++; $display("FAIL enable_resume obs=%h exp=%h", obsA, {1'b1, 32'hF000_0014, 32'h3F3F664F, 4'b0000, 1'b0});
        end
        step();
        tests++;
        if (wWriteA !== 1'b0) begin
            fails++; $display("FAIL enable_resume_quiet obs=%b exp=0", wWriteA);
        end
    endtask

    task automatic test_refresh();
        bit expWr;
        nwReset = 1'b0; step();
        nwReset = 1'b1;
        for (int i = 0; i < 48; i++) begin
            wForceRefresh = (mK[1] == 23);
            step();
            wForceRefresh = 1'b0;
            expWr = (mK[1] % 8 >= 1) && (mK[1] % 8 <= 3);
            tests++;
            if (wWriteB !== expWr) begin
                fails++; $display("FAIL refresh_burst k=%0d obs=%b exp=%b", mK[1], wWriteB, expWr);
            end
            tests++;
            if (obsB !== expVec(1)) begin
                fails++; $display("FAIL refresh_model k=%0d obs=%h exp=%h", mK[1], obsB, expVec(1));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] expAddr [3];
        expAddr[0] = 32'hF000_0010; expAddr[1] = 32'hF000_0014; expAddr[2] = 32'hF000_0018;
        wForceRefresh = 1'b1; step(); wForceRefresh = 1'b0;
        step(); step();
        tests++;
        if (wWriteA !== 1'b1) begin
            fails++; $display("FAIL reset_mid_second_write obs=%b exp=1", wWriteA);
        end
        nwReset = 1'b0; step(); nwReset = 1'b1;
        tests++;
        if (obsA[69:1] !== 69'h0) begin
            fails++; $display("FAIL reset_mid_cleared obs=%h exp=0", obsA[69:1]);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (wWriteA !== 1'b1 || bWriteAddrA !== expAddr[i]) begin
                fails++; $display("FAIL reset_mid_restart%0d write=%b addr=%h exp addr=%h", i, wWriteA, bWriteAddrA, expAddr[i]);
            end
        end
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) begin
                d = int'($urandom_range(9));
                bCode[8*d +: 8] = 8'($urandom);
            end
            wEnable       = ($urandom_range(3) != 0);
            wForceRefresh = ($urandom_range(19) == 0);
            nwReset       = ($urandom_range(99) != 0);
            step();
            tests++;
            if (obsA !== expVec(0)) begin
                fails++; $display("FAIL random_a cycle=%0d obs=%h exp=%h", i, obsA, expVec(0));
            end
            tests++;
            if (obsB !== expVec(1)) begin
                fails++; $display("FAIL random_b cycle=%0d obs=%h exp=%h", i, obsB, expVec(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_single_change();
        test_back_to_back();
        test_enable_hold();
        test_refresh();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg_display_writer.md
# seg_display_writer

Bus-write scheduler for the memory-mapped 7-segment display (ten digits, three 32-bit display words). It watches ten 8-bit segment codes and keeps a shadow copy of what was last written. It issues single-cycle bus writes for changed words in round-robin order, and rewrites all words periodically or on demand. It sits between the dec2seg encoders and the main module's write port, replacing hand-written change-flag logic.

## Interface
- BASEADDR, 32'hF000_0010: address of display word 0; word 1 at BASEADDR+4, word 2 at BASEADDR+8.
- REFRESH_PERIOD, 1000: cycles between forced full rewrites; 0 disables the timer.
- CNTWIDTH, 20: width of the refresh counter; must satisfy REFRESH_PERIOD < 2^CNTWIDTH.

Ports:
- wClk  in  1  clock, all state updates on rising edge.
- nwReset  in  1  reset, synchronous, active-low.
- bCode  in  80  segment codes; digit i = bCode[8*i+7:8*i], i = 0..9.
- wEnable  in  1  1 = writes may be issued; 0 = hold off; changes accumulate.
- wForceRefresh  in  1  single-cycle request to rewrite all three words.
- wWrite  out  1  write strobe, one cycle per write.
- bWriteAddr  out  32  write address.
- bWriteData  out  32  write data.
- bWriteMask  out  4  byte mask; bit set = byte NOT written.
- wBusy  out  1  any word dirty or pending.

## Operation
- Word map:
  - W0 = {d3,d2,d1,d0}, mask 4'b0000.
  - W1 = {d7,d6,d5,d4}, mask 4'b0000.
  - W2 = {16'b0,d9,d8}, mask 4'b1100.
- State:
  - shadow[3]: 32-bit last-written data per word.
  - pend[3]: refresh-pending bits.
  - ptr: 2-bit index of the last granted word.
  - refresh counter.
- dirty[i] = (Wi != shadow[i]) | pend[i], evaluated combinationally every cycle. W2 compares bits [15:0] only.
- Grant: if wEnable=1 and any dirty bit is set, select the first dirty word searching ptr+1, ptr+2, ptr+3 (mod 3).
- On the grant edge:
  - register wWrite=1, bWriteAddr=BASEADDR+4*i, bWriteData=Wi, and the mask for word i.
  - shadow[i] <= Wi, pend[i] <= 0, ptr <= i.
- With no grant: wWrite <= 0. bWriteAddr, bWriteData and bWriteMask hold their last values.
- Refresh counter:
  - increments every cycle; at REFRESH_PERIOD-1 it wraps to 0 and sets pend to 3'b111.
  - is frozen at 0 when REFRESH_PERIOD = 0.
  - runs regardless of wEnable.
- wForceRefresh=1 sets pend to 3'b111.
- Simultaneous events:
  - refresh/force set has priority over the grant clear for the same bit, so no request is lost.
  - the pend bit of a word granted in that same cycle stays 1, giving one extra rewrite.
- wBusy = |dirty, combinational.
- Reset (nwReset=0 at an edge, including mid-sequence):
  - wWrite=0; bWriteAddr, bWriteData, bWriteMask = 0.
  - shadow = 0, pend = 3'b111, ptr = 2, counter = 0.
  - The first writes after reset are therefore W0, W1, W2 in that order.

## Timing
- Latency: bCode change sampled in cycle k gives wWrite=1 in cycle k+1 if that word wins arbitration.
- At most one write per cycle; back-to-back writes allowed. Three dirty words drain in exactly 3 consecutive cycles.
- Each dirty word is served within 3 cycles of being dirty while wEnable=1 (round-robin, no starvation).
- bCode changing on a word in its grant cycle: the value sampled at the grant edge is written. The newer value marks the word dirty again the next cycle.
- wEnable low: no grants; shadow unchanged. On wEnable rising, pending words drain from ptr+1 on the next cycle.
- Repeated identical bCode produces no writes (except refresh).

## Test plan
- Reset, wEnable=1, bCode all 8'h3F, REFRESH_PERIOD=0: writes in cycles 1-3.
  - addr F000_0010 data 3F3F3F3F mask 0000.
  - addr F000_0014 data 3F3F3F3F mask 0000.
  - addr F000_0018 data 00003F3F mask 1100.
  - Then wWrite=0 and wBusy=0.
- After idle, set d0=8'h06: exactly one write next cycle, addr F000_0010 data 3F3F3F06. No further writes.
- Change d1, d5 and d9 in one cycle with ptr=0: writes W1, W2, W0 in consecutive cycles.
- wEnable=0 for 10 cycles while d4 toggles 06→5B→06→4F: no writes during the hold. One write of W1 with d4=4F in the cycle after wEnable returns to 1.
- REFRESH_PERIOD=8, static bCode: a 3-write burst every 8 cycles. A wForceRefresh pulse in the same cycle as the wrap yields a single 3-write burst.
- Assert nwReset=0 during the second write of a burst: outputs are 0 on the next cycle. After release, the full W0, W1, W2 sequence restarts.
